// File: rtl/vcxo_pkg.sv
// Shared types, widths and saturation helpers for the VCXO discipline loop.
package vcxo_pkg;

    localparam int PWM_W  = 16;
    localparam int ERR_W  = 32;
    localparam int WIDE_W = ERR_W + 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_MEASURE = 3'd2;
    localparam state_t ST_COMPUTE = 3'd3;
    localparam state_t ST_APPLY   = 3'd4;

    localparam logic signed [WIDE_W-1:0] ERR_MAX_WIDE =
        {{(WIDE_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] ERR_MIN_WIDE =
        {{(WIDE_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [WIDE_W-1:0] v);
        if (v > ERR_MAX_WIDE) return {1'b0, {(ERR_W-1){1'b1}}};
        if (v < ERR_MIN_WIDE) return {1'b1, {(ERR_W-1){1'b0}}};
        return v[ERR_W-1:0];
    endfunction

    function automatic logic [PWM_W-1:0] clamp_pwm(input logic signed [WIDE_W-1:0] v,
                                                   input logic [PWM_W-1:0]        lo,
                                                   input logic [PWM_W-1:0]        hi);
        if (v < $signed({{(WIDE_W-PWM_W){1'b0}}, lo})) return lo;
        if (v > $signed({{(WIDE_W-PWM_W){1'b0}}, hi})) return hi;
        return v[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/vcxo_step_calc.sv
// Combinational error, two-rate step and clamped next setpoint for one measurement.
module vcxo_step_calc
    import vcxo_pkg::*;
#(
    parameter int NOMINAL_COUNT = 12288000,
    parameter int PWM_MIN       = 2,
    parameter int PWM_MAX       = 39999,
    parameter int TRACK_THRESH  = 64,
    parameter int TRACK_SHIFT   = 2
) (
    input  logic [31:0]              count_i,
    input  logic signed [15:0]       correction_i,
    input  logic [PWM_W-1:0]         pwm_i,
    output logic signed [ERR_W-1:0]  err_o,
    output logic [ERR_W-1:0]         abs_err_o,
    output logic [PWM_W-1:0]         new_pwm_o
);

    localparam logic signed [ERR_W-1:0] PLUS_ONE  = 1;
    localparam logic signed [ERR_W-1:0] MINUS_ONE = -1;
    localparam logic [ERR_W-1:0]        ONE_U     = 1;

    logic signed [WIDE_W-1:0] err_wide;
    logic signed [WIDE_W-1:0] new_wide;
    logic [ERR_W-1:0]         err_u;
    logic signed [ERR_W-1:0]  shifted;
    logic signed [ERR_W-1:0]  step;

    assign err_wide  = $signed({{(WIDE_W-32){1'b0}}, count_i})
                     - WIDE_W'(NOMINAL_COUNT) + WIDE_W'(correction_i);
    assign err_o     = sat_err(err_wide);
    assign err_u     = err_o;
    assign abs_err_o = err_u[ERR_W-1] ? (~err_u + ONE_U) : err_u;
    assign shifted   = err_o >>> TRACK_SHIFT;

    // Fine steps never stall at zero while an error remains.
    always_comb begin
        step = err_o;
        if (abs_err_o < 32'(TRACK_THRESH)) begin
            step = shifted;
            if (shifted == '0 && err_o != '0) begin
                step = err_o[ERR_W-1] ? MINUS_ONE : PLUS_ONE;
            end
        end
    end

    assign new_wide  = $signed({{(WIDE_W-PWM_W){1'b0}}, pwm_i}) - WIDE_W'(step);
    assign new_pwm_o = clamp_pwm(new_wide, PWM_W'(PWM_MIN), PWM_W'(PWM_MAX));

endmodule

// File: rtl/vcxo_loop_sequencer.sv
// VCXO frequency-discipline sequencer: measure, compute, step PWM, track lock.
// Define VCXO_SEQ_TX_PRESET_EN for separate RX/TX setpoint slots.
module vcxo_loop_sequencer
    import vcxo_pkg::*;
#(
    parameter int NOMINAL_COUNT  = 12288000,
    parameter int PWM_INIT       = 20000,
    parameter int PWM_MIN        = 2,
    parameter int PWM_MAX        = 39999,
    parameter int TRACK_THRESH   = 64,
    parameter int TRACK_SHIFT    = 2,
    parameter int LOCK_TOL       = 2,
    parameter int UNLOCK_TOL     = 20,
    parameter int LOCK_COUNT     = 4,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     enable_in,
    input  logic                     tx_in,
    input  logic signed [15:0]       correction_in,
    output logic                     meas_req,
    input  logic                     meas_ack,
    input  logic [31:0]              meas_count,
    output logic [PWM_W-1:0]         pwm,
    output logic                     pwm_load,
    output logic signed [ERR_W-1:0]  freq_error,
    output logic                     locked,
    output logic                     fault,
    output logic [2:0]               state
);

    localparam logic [31:0]      SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [PWM_W-1:0] PWM_RST      = PWM_W'(PWM_INIT);
    localparam logic [3:0]       LOCK_N       = 4'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] LOCK_TOL_U   = ERR_W'(LOCK_TOL);
    localparam logic [ERR_W-1:0] UNLOCK_TOL_U = ERR_W'(UNLOCK_TOL);

    state_t                  state_q, state_d;
    logic [31:0]             cyc_q, cyc_d;
    logic                    meas_req_q, meas_req_d;
    logic [31:0]             count_q, count_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0]        abs_q, abs_d;
    logic [PWM_W-1:0]        new_q, new_d;
    logic [PWM_W-1:0]        pwm_q, pwm_d, pwm_mode;
    logic                    pwm_load_q, pwm_load_d;
    logic signed [ERR_W-1:0] freq_error_q, freq_error_d;
    logic                    locked_q, locked_d;
    logic                    fault_q, fault_d;
    logic [3:0]              lock_cnt_q, lock_cnt_d;
    logic                    mode_q, mode_d;
    logic                    tx_change, switch_mode;

    logic signed [ERR_W-1:0] calc_err;
    logic [ERR_W-1:0]        calc_abs;
    logic [PWM_W-1:0]        calc_new;

    vcxo_step_calc #(
        .NOMINAL_COUNT (NOMINAL_COUNT),
        .PWM_MIN       (PWM_MIN),
        .PWM_MAX       (PWM_MAX),
        .TRACK_THRESH  (TRACK_THRESH),
        .TRACK_SHIFT   (TRACK_SHIFT)
    ) u_step_calc (
        .count_i      (count_q),
        .correction_i (correction_in),
        .pwm_i        (pwm_q),
        .err_o        (calc_err),
        .abs_err_o    (calc_abs),
        .new_pwm_o    (calc_new)
    );

`ifdef VCXO_SEQ_TX_PRESET_EN
    logic [PWM_W-1:0] slot_q [2];

    // The active mode's slot always mirrors the live setpoint.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
                slot_q[gi] <= PWM_RST;
            end else if (mode_q == 1'(gi)) begin
                slot_q[gi] <= pwm_mode;
            end
        end
    end
`endif

    assign tx_change = (tx_in != mode_q);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q + 32'd1;
        meas_req_d   = meas_req_q;
        count_d      = count_q;
        err_d        = err_q;
        abs_d        = abs_q;
        new_d        = new_q;
        pwm_mode     = pwm_q;
        pwm_load_d   = 1'b0;
        freq_error_d = freq_error_q;
        locked_d     = locked_q;
        fault_d      = fault_q;
        lock_cnt_d   = lock_cnt_q;
        switch_mode  = 1'b0;

        if (!enable_in) begin
            state_d    = ST_IDLE;
            cyc_d      = '0;
            meas_req_d = 1'b0;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SETTLE;
                    cyc_d       = '0;
                    switch_mode = tx_change;
                end
                ST_SETTLE: begin
                    if (tx_change) begin
                        switch_mode = 1'b1;
                        cyc_d       = '0;
                    end else if (cyc_q == SETTLE_LAST) begin
                        state_d = ST_MEASURE;
                        cyc_d   = '0;
                    end
                end
                ST_MEASURE: begin
                    // Mode change beats ack; ack beats timeout.
                    if (tx_change) begin
                        switch_mode = 1'b1;
                        meas_req_d  = 1'b0;
                        state_d     = ST_SETTLE;
                        cyc_d       = '0;
                    end else if (!meas_req_q) begin
                        meas_req_d = 1'b1;
                        cyc_d      = '0;
                    end else if (meas_ack) begin
                        count_d    = meas_count;
                        meas_req_d = 1'b0;
                        state_d    = ST_COMPUTE;
                    end else if (cyc_q == TIMEOUT_LAST) begin
                        fault_d    = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                        meas_req_d = 1'b0;
                        state_d    = ST_SETTLE;
                        cyc_d      = '0;
                    end
                end
                ST_COMPUTE: begin
                    err_d   = calc_err;
                    abs_d   = calc_abs;
                    new_d   = calc_new;
                    state_d = ST_APPLY;
                end
                ST_APPLY: begin
                    pwm_mode     = new_q;
                    pwm_load_d   = (new_q != pwm_q);
                    freq_error_d = err_q;
                    fault_d      = 1'b0;
                    if (abs_q <= LOCK_TOL_U) begin
                        if (lock_cnt_q != LOCK_N) lock_cnt_d = lock_cnt_q + 4'd1;
                    end else begin
                        lock_cnt_d = '0;
                    end
                    if (lock_cnt_d == LOCK_N) begin
                        locked_d = 1'b1;
                    end else if (abs_q > UNLOCK_TOL_U) begin
                        locked_d = 1'b0;
                    end
                    state_d = ST_MEASURE;
                    cyc_d   = '0;
                    if (tx_change) begin
                        switch_mode = 1'b1;
                        state_d     = ST_SETTLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    meas_req_d = 1'b0;
                end
            endcase
        end

        mode_d = switch_mode ? tx_in : mode_q;
        pwm_d  = pwm_mode;
        if (switch_mode) lock_cnt_d = '0;
`ifdef VCXO_SEQ_TX_PRESET_EN
        if (switch_mode) begin
            pwm_d      = slot_q[tx_in];
            pwm_load_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            meas_req_q   <= 1'b0;
            count_q      <= '0;
            err_q        <= '0;
            abs_q        <= '0;
            new_q        <= PWM_RST;
            pwm_q        <= PWM_RST;
            pwm_load_q   <= 1'b0;
            freq_error_q <= '0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            lock_cnt_q   <= '0;
            mode_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            meas_req_q   <= meas_req_d;
            count_q      <= count_d;
            err_q        <= err_d;
            abs_q        <= abs_d;
            new_q        <= new_d;
            pwm_q        <= pwm_d;
            pwm_load_q   <= pwm_load_d;
            freq_error_q <= freq_error_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            lock_cnt_q   <= lock_cnt_d;
            mode_q       <= mode_d;
        end
    end

    assign meas_req   = meas_req_q;
    assign pwm        = pwm_q;
    assign pwm_load   = pwm_load_q;
    assign freq_error = freq_error_q;
    assign locked     = locked_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_vcxo_loop_sequencer.sv
// Directed bench for vcxo_loop_sequencer with shortened settle and timeout windows.
module tb_vcxo_loop_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               tx = 1'b0;
    logic signed [15:0] correction = 16'sd0;
    logic               meas_ack = 1'b0;
    logic [31:0]        meas_count = 32'd0;
    logic               meas_req;
    logic [15:0]        pwm;
    logic               pwm_load;
    logic signed [31:0] freq_error;
    logic               locked;
    logic               fault;
    logic [2:0]         state;

    int errors = 0;
    int checks = 0;

`ifdef VCXO_SEQ_TX_PRESET_EN
    localparam bit PRESET = 1'b1;
`else
    localparam bit PRESET = 1'b0;
`endif

    vcxo_loop_sequencer #(
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .enable_in     (enable),
        .tx_in         (tx),
        .correction_in (correction),
        .meas_req      (meas_req),
        .meas_ack      (meas_ack),
        .meas_count    (meas_count),
        .pwm           (pwm),
        .pwm_load      (pwm_load),
        .freq_error    (freq_error),
        .locked        (locked),
        .fault         (fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (meas_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(meas_req), 32'd1);
    endtask

    task automatic meas(input string tag, input logic [31:0] cnt, input logic [15:0] exp_pwm,
                        input logic exp_load, input logic [31:0] exp_err);
        wait_req(tag);
        meas_count = cnt;
        meas_ack   = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
        chk({tag, "_drop"}, 32'(meas_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_pwm"}, 32'(pwm), 32'(exp_pwm));
        chk({tag, "_load"}, 32'(pwm_load), 32'(exp_load));
        chk({tag, "_err"}, freq_error, exp_err);
        $display("meas %s: count=%0d pwm=%0d load=%0b err=%0d", tag, cnt, pwm, pwm_load, freq_error);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm), 32'd20000);
        chk("rst_req", 32'(meas_req), 32'd0);
        chk("rst_load", 32'(pwm_load), 32'd0);
        chk("rst_err", freq_error, 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("en_state", 32'(state), 32'd1);

        // First measurement with full latency checks: err +100 -> 19900.
        wait_req("m100");
        meas_count = 32'd12288100;
        meas_ack   = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
        chk("m100_compute", 32'(state), 32'd3);
        chk("m100_drop", 32'(meas_req), 32'd0);
        @(negedge clk);
        chk("m100_apply", 32'(state), 32'd4);
        @(negedge clk);
        chk("m100_pwm", 32'(pwm), 32'd19900);
        chk("m100_load", 32'(pwm_load), 32'd1);
        chk("m100_err", freq_error, 32'd100);
        chk("m100_state", 32'(state), 32'd2);
        chk("m100_req_low", 32'(meas_req), 32'd0);
        @(negedge clk);
        chk("m100_req_back", 32'(meas_req), 32'd1);
        chk("m100_load_pulse", 32'(pwm_load), 32'd0);
        $display("meas m100: count=12288100 pwm=%0d err=%0d", pwm, freq_error);

        meas("e_p1", 32'd12288001, 16'd19899, 1'b1, 32'd1);
        meas("e_0", 32'd12288000, 16'd19899, 1'b0, 32'd0);
        meas("e_m3", 32'd12287997, 16'd19900, 1'b1, -32'sd3);
        meas("e_p10", 32'd12288010, 16'd19898, 1'b1, 32'd10);

        meas("lk1", 32'd12288002, 16'd19897, 1'b1, 32'd2);
        meas("lk2", 32'd12288002, 16'd19896, 1'b1, 32'd2);
        meas("lk3", 32'd12288002, 16'd19895, 1'b1, 32'd2);
        chk("lk3_locked", 32'(locked), 32'd0);
        meas("lk4", 32'd12288002, 16'd19894, 1'b1, 32'd2);
        chk("lk4_locked", 32'(locked), 32'd1);
        meas("hold15", 32'd12288015, 16'd19891, 1'b1, 32'd15);
        chk("hold15_locked", 32'(locked), 32'd1);
        meas("unlk21", 32'd12288021, 16'd19886, 1'b1, 32'd21);
        chk("unlk21_locked", 32'(locked), 32'd0);

        meas("clamp_hi", 32'd12238000, 16'd39999, 1'b1, -32'sd50000);
        meas("clamp_lo", 32'd12338000, 16'd2, 1'b1, 32'd50000);
        correction = 16'sd5;
        meas("corr5", 32'd12288000, 16'd2, 1'b0, 32'd5);
        correction = 16'sd0;
        meas("sat", 32'hFFFF_FFFF, 16'd2, 1'b0, 32'h7FFF_FFFF);

        for (int i = 0; i < 4; i++) meas("relock", 32'd12288002, 16'd2, 1'b0, 32'd2);
        chk("relock_locked", 32'(locked), 32'd1);

        // No ack: wait for the timeout to fire.
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_state", 32'(state), 32'd1);
        chk("to_req", 32'(meas_req), 32'd0);
        meas("recover", 32'd12288002, 16'd2, 1'b0, 32'd2);
        chk("recover_fault", 32'(fault), 32'd0);
        for (int i = 0; i < 3; i++) meas("lock_again", 32'd12288002, 16'd2, 1'b0, 32'd2);
        chk("lock_again_locked", 32'(locked), 32'd1);

        // Mode switch mid-MEASURE.
        wait_req("tx_up");
        tx = 1'b1;
        @(negedge clk);
        chk("tx_up_req", 32'(meas_req), 32'd0);
        chk("tx_up_state", 32'(state), 32'd1);
        chk("tx_up_pwm", 32'(pwm), PRESET ? 32'd20000 : 32'd2);
        chk("tx_up_load", 32'(pwm_load), PRESET ? 32'd1 : 32'd0);
        chk("tx_up_locked", 32'(locked), 32'd1);
        $display("txsw up: pwm=%0d load=%0b", pwm, pwm_load);

        meas_count = 32'd12288100;
        meas_ack   = 1'b1;
        @(negedge clk);
        meas_ack = 1'b0;
        chk("stray_state", 32'(state), 32'd1);
        chk("stray_err", freq_error, 32'd2);

        // Ack and mode change on the same edge: mode change wins.
        wait_req("tx_dn");
        meas_count = 32'd12288100;
        meas_ack   = 1'b1;
        tx         = 1'b0;
        @(negedge clk);
        meas_ack = 1'b0;
        chk("tx_dn_state", 32'(state), 32'd1);
        chk("tx_dn_req", 32'(meas_req), 32'd0);
        chk("tx_dn_pwm", 32'(pwm), 32'd2);
        chk("tx_dn_load", 32'(pwm_load), PRESET ? 32'd1 : 32'd0);
        chk("tx_dn_err", freq_error, 32'd2);
        @(negedge clk);
        chk("tx_dn_discard", 32'(state), 32'd1);
        $display("txsw down: pwm=%0d err=%0d", pwm, freq_error);

        wait_req("dis");
        enable = 1'b0;
        @(negedge clk);
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_req", 32'(meas_req), 32'd0);
        chk("dis_locked", 32'(locked), 32'd0);
        chk("dis_pwm", 32'(pwm), 32'd2);

        enable = 1'b1;
        wait_req("mid_rst");
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_pwm", 32'(pwm), 32'd20000);
        chk("mrst_req", 32'(meas_req), 32'd0);
        chk("mrst_load", 32'(pwm_load), 32'd0);
        chk("mrst_err", freq_error, 32'd0);
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_fault", 32'(fault), 32'd0);
        chk("mrst_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
